// File: rtl/fetch_unit_if.sv
// Controller/memory-facing bundle of the fetch unit.
// The slave modport is the fetch unit's view; master is its environment.
interface fetch_unit_if;
    logic        PC_WRITE;
    logic        PC_SEL;
    logic        BR_SEL;
    logic        PC_RST;
    logic [3:0]  FLAGS_IN;
    logic        FLAGS_WE;
    logic        MEM_ACK;
    logic [31:0] MEM_RDATA;
    logic        MEM_REQ;
    logic [15:0] MEM_ADDR;
    logic [3:0]  OPCODE;
    logic [3:0]  MM;
    logic [3:0]  STAT;
    logic [15:0] PC;
    logic        IR_VALID;
    logic        BUSY;
    logic        FETCH_ERR;

    modport slave (
        input  PC_WRITE, PC_SEL, BR_SEL, PC_RST, FLAGS_IN, FLAGS_WE, MEM_ACK, MEM_RDATA,
        output MEM_REQ, MEM_ADDR, OPCODE, MM, STAT, PC, IR_VALID, BUSY, FETCH_ERR
    );

    modport master (
        output PC_WRITE, PC_SEL, BR_SEL, PC_RST, FLAGS_IN, FLAGS_WE, MEM_ACK, MEM_RDATA,
        input  MEM_REQ, MEM_ADDR, OPCODE, MM, STAT, PC, IR_VALID, BUSY, FETCH_ERR
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC, instruction register, status flags and a
// single-outstanding memory read with a 16-cycle timeout.
module fetch_unit (
    input  logic         CLK,
    input  logic         RST_F,
    fetch_unit_if.slave  bus
);
    localparam int unsigned PC_W   = 16;
    localparam int unsigned IR_W   = 32;
    localparam int unsigned FLAG_W = 4;
    localparam int unsigned CNT_W  = 4;

    localparam logic [3:0] OP_BRA = 4'd4;
    localparam logic [3:0] OP_BRR = 4'd5;
    localparam logic [3:0] OP_BNE = 4'd6;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_FAULT} state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [IR_W-1:0]   ir_q, ir_d;
    logic [FLAG_W-1:0] stat_q, stat_d;
    logic              ir_valid_q, ir_valid_d;
    logic              mem_req_q, mem_req_d;
    logic [PC_W-1:0]   mem_addr_q, mem_addr_d;
    logic              busy_q, busy_d;
    logic              fetch_err_q, fetch_err_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic              pending_q, pending_d;

    logic [3:0]        opcode;
    logic [3:0]        mm;
    logic              br_take;
    logic [PC_W-1:0]   br_target;
    logic              unused_ir_bits;

    assign opcode         = ir_q[31:28];
    assign mm             = ir_q[27:24];
    assign unused_ir_bits = ^ir_q[23:16];

    // Branch resolution from the current IR; bne tests the pre-update flags.
    always_comb begin
        br_take   = 1'b0;
        br_target = pc_q;
        if (bus.BR_SEL) begin
            case (opcode)
                OP_BRA: begin
                    br_take   = 1'b1;
                    br_target = ir_q[15:0];
                end
                OP_BRR: begin
                    br_take   = 1'b1;
                    br_target = PC_W'(pc_q + PC_W'({{(PC_W-16){ir_q[15]}}, ir_q[15:0]}));
                end
                OP_BNE: begin
                    br_take   = ((stat_q & mm) == 4'b0000);
                    br_target = ir_q[15:0];
                end
                default: ;
            endcase
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        stat_d      = bus.FLAGS_WE ? bus.FLAGS_IN : stat_q;
        ir_valid_d  = ir_valid_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        busy_d      = busy_q;
        fetch_err_d = fetch_err_q;
        wait_cnt_d  = wait_cnt_q;
        pending_d   = pending_q;

        if (bus.PC_RST) begin
            state_d     = S_IDLE;
            pc_d        = '0;
            stat_d      = stat_q;
            mem_req_d   = 1'b0;
            busy_d      = 1'b0;
            fetch_err_d = 1'b0;
            wait_cnt_d  = '0;
            pending_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pending_q || (bus.PC_WRITE && !bus.PC_SEL)) begin
                        state_d    = S_REQ;
                        mem_req_d  = 1'b1;
                        mem_addr_d = pc_q;
                        busy_d     = 1'b1;
                        wait_cnt_d = '0;
                        pending_d  = 1'b0;
                    end else if (bus.PC_SEL) begin
                        if (br_take) pc_d = br_target;
                        pending_d = bus.PC_WRITE;
                    end
                end
                S_REQ: begin
                    if (bus.MEM_ACK) begin
                        state_d    = S_IDLE;
                        ir_d       = bus.MEM_RDATA;
                        pc_d       = PC_W'(pc_q + PC_W'(1));
                        ir_valid_d = 1'b1;
                        mem_req_d  = 1'b0;
                        busy_d     = 1'b0;
                    end else if (wait_cnt_q == '1) begin
                        state_d     = S_FAULT;
                        fetch_err_d = 1'b1;
                        mem_req_d   = 1'b0;
                        busy_d      = 1'b0;
                    end else begin
                        wait_cnt_d = CNT_W'(wait_cnt_q + CNT_W'(1));
                    end
                end
                S_FAULT: ;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_F) begin
        if (!RST_F) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            ir_q        <= '0;
            stat_q      <= '0;
            ir_valid_q  <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            busy_q      <= 1'b0;
            fetch_err_q <= 1'b0;
            wait_cnt_q  <= '0;
            pending_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            stat_q      <= stat_d;
            ir_valid_q  <= ir_valid_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            busy_q      <= busy_d;
            fetch_err_q <= fetch_err_d;
            wait_cnt_q  <= wait_cnt_d;
            pending_q   <= pending_d;
        end
    end

    assign bus.MEM_REQ   = mem_req_q;
    assign bus.MEM_ADDR  = mem_addr_q;
    assign bus.OPCODE    = opcode;
    assign bus.MM        = mm;
    assign bus.STAT      = stat_q;
    assign bus.PC        = pc_q;
    assign bus.IR_VALID  = ir_valid_q;
    assign bus.BUSY      = busy_q;
    assign bus.FETCH_ERR = fetch_err_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a per-cycle vector table for fetch/branch
// behaviour plus hand-written timeout and asynchronous-reset sequences.
module tb_fetch_unit;
    logic CLK;
    logic RST_F;

    fetch_unit_if bus ();

    fetch_unit dut (
        .CLK   (CLK),
        .RST_F (RST_F),
        .bus   (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Control bit positions: {PC_WRITE, PC_SEL, BR_SEL, PC_RST, FLAGS_WE}
    localparam logic [4:0] W   = 5'b10000;
    localparam logic [4:0] SEL = 5'b01000;
    localparam logic [4:0] BR  = 5'b00100;
    localparam logic [4:0] RST = 5'b00010;
    localparam logic [4:0] FWE = 5'b00001;
    localparam logic [4:0] NON = 5'b00000;

    typedef struct {
        logic [4:0]  ctl;
        logic [3:0]  flags;
        logic        ack;
        logic [31:0] rdata;
        logic [47:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    // Expected outputs packed as {MEM_REQ, MEM_ADDR, OPCODE, MM, STAT, PC, IR_VALID, BUSY, FETCH_ERR}
    function automatic logic [47:0] pk(input logic req, input logic [15:0] addr,
                                       input logic [3:0] op, input logic [3:0] mm,
                                       input logic [3:0] st, input logic [15:0] pc,
                                       input logic [2:0] vbe);
        return {req, addr, op, mm, st, pc, vbe};
    endfunction

    function automatic logic [47:0] act();
        return {bus.MEM_REQ, bus.MEM_ADDR, bus.OPCODE, bus.MM, bus.STAT, bus.PC,
                bus.IR_VALID, bus.BUSY, bus.FETCH_ERR};
    endfunction

    function automatic vec_t mk(input logic [4:0] ctl, input logic [3:0] flags,
                                input logic ack, input logic [31:0] rdata,
                                input logic [47:0] exp);
        vec_t v;
        v.ctl = ctl; v.flags = flags; v.ack = ack; v.rdata = rdata; v.exp = exp;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [47:0] a, input logic [47:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, a, e);
        end
    endtask

    task automatic drive(input logic [4:0] ctl, input logic [3:0] flags,
                         input logic ack, input logic [31:0] rdata);
        bus.PC_WRITE  = ctl[4];
        bus.PC_SEL    = ctl[3];
        bus.BR_SEL    = ctl[2];
        bus.PC_RST    = ctl[1];
        bus.FLAGS_WE  = ctl[0];
        bus.FLAGS_IN  = flags;
        bus.MEM_ACK   = ack;
        bus.MEM_RDATA = rdata;
    endtask

    task automatic cyc(input logic [4:0] ctl, input logic [3:0] flags,
                       input logic ack, input logic [31:0] rdata);
        @(negedge CLK);
        drive(ctl, flags, ack, rdata);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // fetch 0x81000005 with a 3-cycle ack latency
        vecs.push_back(mk(W,        0, 0, 32'h0,        pk(1, 16'h0000, 0, 0, 0, 16'h0000, 3'b010)));
        vecs.push_back(mk(NON,      0, 0, 32'h0,        pk(1, 16'h0000, 0, 0, 0, 16'h0000, 3'b010)));
        vecs.push_back(mk(NON,      0, 0, 32'h0,        pk(1, 16'h0000, 0, 0, 0, 16'h0000, 3'b010)));
        vecs.push_back(mk(NON,      0, 1, 32'h81000005, pk(0, 16'h0000, 8, 1, 0, 16'h0001, 3'b100)));
        // bra 0x0020
        vecs.push_back(mk(W,        0, 0, 32'h0,        pk(1, 16'h0001, 8, 1, 0, 16'h0001, 3'b110)));
        vecs.push_back(mk(NON,      0, 1, 32'h40000020, pk(0, 16'h0001, 4, 0, 0, 16'h0002, 3'b100)));
        vecs.push_back(mk(SEL|BR,   0, 0, 32'h0,        pk(0, 16'h0001, 4, 0, 0, 16'h0020, 3'b100)));
        // brr -2 from 0x0021
        vecs.push_back(mk(W,        0, 0, 32'h0,        pk(1, 16'h0020, 4, 0, 0, 16'h0020, 3'b110)));
        vecs.push_back(mk(NON,      0, 1, 32'h5000FFFE, pk(0, 16'h0020, 5, 0, 0, 16'h0021, 3'b100)));
        vecs.push_back(mk(SEL|BR,   0, 0, 32'h0,        pk(0, 16'h0020, 5, 0, 0, 16'h001F, 3'b100)));
        vecs.push_back(mk(SEL,      0, 0, 32'h0,        pk(0, 16'h0020, 5, 0, 0, 16'h001F, 3'b100)));
        // bne taken/not taken against STAT=0100
        vecs.push_back(mk(FWE,      4, 0, 32'h0,        pk(0, 16'h0020, 5, 0, 4, 16'h001F, 3'b100)));
        vecs.push_back(mk(W,        0, 0, 32'h0,        pk(1, 16'h001F, 5, 0, 4, 16'h001F, 3'b110)));
        vecs.push_back(mk(NON,      0, 1, 32'h64000100, pk(0, 16'h001F, 6, 4, 4, 16'h0020, 3'b100)));
        vecs.push_back(mk(SEL|BR,   0, 0, 32'h0,        pk(0, 16'h001F, 6, 4, 4, 16'h0020, 3'b100)));
        vecs.push_back(mk(W,        0, 0, 32'h0,        pk(1, 16'h0020, 6, 4, 4, 16'h0020, 3'b110)));
        vecs.push_back(mk(NON,      0, 1, 32'h63000100, pk(0, 16'h0020, 6, 3, 4, 16'h0021, 3'b100)));
        vecs.push_back(mk(SEL|BR|FWE, 1, 0, 32'h0,      pk(0, 16'h0020, 6, 3, 1, 16'h0100, 3'b100)));
        // stray ack in IDLE
        vecs.push_back(mk(NON,      0, 1, 32'hDEADBEEF, pk(0, 16'h0020, 6, 3, 1, 16'h0100, 3'b100)));
        // PC wrap at 0xFFFF, PC_WRITE ignored during REQ
        vecs.push_back(mk(W,        0, 0, 32'h0,        pk(1, 16'h0100, 6, 3, 1, 16'h0100, 3'b110)));
        vecs.push_back(mk(NON,      0, 1, 32'h4000FFFF, pk(0, 16'h0100, 4, 0, 1, 16'h0101, 3'b100)));
        vecs.push_back(mk(SEL|BR,   0, 0, 32'h0,        pk(0, 16'h0100, 4, 0, 1, 16'hFFFF, 3'b100)));
        vecs.push_back(mk(W,        0, 0, 32'h0,        pk(1, 16'hFFFF, 4, 0, 1, 16'hFFFF, 3'b110)));
        vecs.push_back(mk(W,        0, 0, 32'h0,        pk(1, 16'hFFFF, 4, 0, 1, 16'hFFFF, 3'b110)));
        vecs.push_back(mk(NON,      0, 1, 32'h40000040, pk(0, 16'hFFFF, 4, 0, 1, 16'h0000, 3'b100)));
        // branch and fetch request in the same cycle
        vecs.push_back(mk(W|SEL|BR, 0, 0, 32'h0,        pk(0, 16'hFFFF, 4, 0, 1, 16'h0040, 3'b100)));
        vecs.push_back(mk(NON,      0, 0, 32'h0,        pk(1, 16'h0040, 4, 0, 1, 16'h0040, 3'b110)));
        vecs.push_back(mk(NON,      0, 1, 32'h00000000, pk(0, 16'h0040, 0, 0, 1, 16'h0041, 3'b100)));
        vecs.push_back(mk(SEL|BR,   0, 0, 32'h0,        pk(0, 16'h0040, 0, 0, 1, 16'h0041, 3'b100)));
        // PC_RST mid-fetch overrides ack and flag write
        vecs.push_back(mk(W,        0, 0, 32'h0,        pk(1, 16'h0041, 0, 0, 1, 16'h0041, 3'b110)));
        vecs.push_back(mk(RST|FWE,  4'hF, 1, 32'h12345678, pk(0, 16'h0041, 0, 0, 1, 16'h0000, 3'b100)));
        vecs.push_back(mk(NON,      0, 1, 32'h12345678, pk(0, 16'h0041, 0, 0, 1, 16'h0000, 3'b100)));

        RST_F = 1'b0;
        drive(NON, 0, 1'b0, 32'h0);
        #12;
        chk("reset_hold", act(), 48'h0);
        @(negedge CLK);
        RST_F = 1'b1;
        @(posedge CLK);
        #1;
        chk("reset_release", act(), 48'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].ctl, vecs[i].flags, vecs[i].ack, vecs[i].rdata);
            chk($sformatf("vec%0d", i), act(), vecs[i].exp);
        end

        // timeout: 16 unacknowledged REQ cycles
        cyc(W, 0, 0, 32'h0);
        chk("to_enter", act(), pk(1, 16'h0000, 0, 0, 1, 16'h0000, 3'b110));
        for (int k = 1; k < 16; k++) begin
            cyc(NON, 0, 0, 32'h0);
            chk($sformatf("to_wait%0d", k), act(), pk(1, 16'h0000, 0, 0, 1, 16'h0000, 3'b110));
        end
        cyc(NON, 0, 0, 32'h0);
        chk("to_fault", act(), pk(0, 16'h0000, 0, 0, 1, 16'h0000, 3'b101));
        cyc(W, 0, 1, 32'h11111111);
        chk("fault_ignore", act(), pk(0, 16'h0000, 0, 0, 1, 16'h0000, 3'b101));
        cyc(RST, 0, 0, 32'h0);
        chk("fault_clear", act(), pk(0, 16'h0000, 0, 0, 1, 16'h0000, 3'b100));
        cyc(W, 0, 0, 32'h0);
        chk("refetch", act(), pk(1, 16'h0000, 0, 0, 1, 16'h0000, 3'b110));
        cyc(FWE, 4'hF, 1, 32'h81000005);
        chk("refetch_done", act(), pk(0, 16'h0000, 8, 1, 4'hF, 16'h0001, 3'b100));

        // asynchronous reset in the middle of a fetch
        cyc(W, 0, 0, 32'h0);
        chk("pre_reset_req", act(), pk(1, 16'h0001, 8, 1, 4'hF, 16'h0001, 3'b110));
        drive(NON, 0, 1'b0, 32'h0);
        #2;
        RST_F = 1'b0;
        #1;
        chk("async_reset", act(), 48'h0);
        @(negedge CLK);
        RST_F = 1'b1;
        drive(NON, 0, 1'b1, 32'hFFFFFFFF);
        @(posedge CLK);
        #1;
        chk("late_ack", act(), 48'h0);
        cyc(NON, 0, 0, 32'h0);
        chk("post_reset_idle", act(), 48'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have ports, clock and reset first; reset RST_F, asynchronous, active-low; clock CLK:
  CLK        in   1   system clock, all state on rising edge
  RST_F      in   1   asynchronous active-low reset
  PC_WRITE   in   1   fetch request pulse from controller
  PC_SEL     in   1   apply branch target to PC
  BR_SEL     in   1   current instruction is a branch
  PC_RST     in   1   synchronous PC clear, aborts fetch
  FLAGS_IN   in   4   ALU status flags
  FLAGS_WE   in   1   load FLAGS_IN into status register
  MEM_ACK    in   1   instruction memory data valid
  MEM_RDATA  in   32  instruction word
  MEM_REQ    out  1   memory read request
  MEM_ADDR   out  16  fetch address
  OPCODE     out  4   IR[31:28]
  MM         out  4   IR[27:24]
  STAT       out  4   registered status flags
  PC         out  16  program counter
  IR_VALID   out  1   IR holds a fetched word
  BUSY       out  1   fetch in progress
  FETCH_ERR  out  1   memory timeout, sticky

Function
REQ-002 SHALL implement states IDLE, REQ, FAULT; all outputs registered except OPCODE/MM (direct IR slices).
REQ-003 IDLE + PC_WRITE=1 (PC_SEL=0) SHALL go to REQ next cycle: MEM_REQ=1, MEM_ADDR=PC, BUSY=1.
REQ-004 MEM_REQ and MEM_ADDR SHALL hold stable in REQ until MEM_ACK=1.
REQ-005 REQ + MEM_ACK=1 SHALL, same edge: IR<=MEM_RDATA, PC<=PC+1 (mod 2^16, 0xFFFF wraps to 0x0000), IR_VALID<=1, MEM_REQ<=0, BUSY<=0, state IDLE.
REQ-006 MEM_ACK outside REQ SHALL be ignored.
REQ-007 PC_WRITE in REQ or FAULT SHALL be ignored (no queueing).
REQ-008 Wait counter (4 bit) SHALL clear on REQ entry, increment each REQ cycle without MEM_ACK; 16th such cycle SHALL enter FAULT: FETCH_ERR=1, MEM_REQ=0, BUSY=0.
REQ-009 FAULT SHALL be exited only by RST_F low or PC_RST=1 (-> IDLE, FETCH_ERR=0).
REQ-010 PC_SEL=1 in IDLE with BR_SEL=1 SHALL update PC per OPCODE: 4 (bra) PC<=IR[15:0]; 5 (brr) PC<=PC+sign-extended IR[15:0], mod 2^16; 6 (bne) as bra only if (STAT & MM)==4'b0000, else PC unchanged.
REQ-011 PC_SEL=1 with BR_SEL=0, other opcode, or outside IDLE SHALL leave PC unchanged.
REQ-012 PC_WRITE and PC_SEL both high in IDLE: branch applied that edge, pending flag set; fetch SHALL start next cycle from updated PC (REQ entered 2 cycles after the event).
REQ-013 FLAGS_WE=1 SHALL load STAT<=FLAGS_IN next edge, any state; a bne evaluated same edge SHALL use the old STAT.
REQ-014 PC_RST=1 SHALL, next edge, any state: PC<=0, MEM_REQ<=0, BUSY<=0, pending<=0, state IDLE; IR, IR_VALID, STAT unchanged; priority over all other inputs.

Reset
REQ-015 RST_F low SHALL immediately force: state IDLE, PC=0x0000, IR=0 (OPCODE=0 noop, MM=0), STAT=0, IR_VALID=0, MEM_REQ=0, MEM_ADDR=0, BUSY=0, FETCH_ERR=0, counter=0, pending=0.
REQ-016 Assertion mid-fetch SHALL drop MEM_REQ asynchronously; a late MEM_ACK after release SHALL be ignored.

Verification
REQ-017 Reset, PC_WRITE pulse, MEM_ACK 3 cycles after MEM_REQ with 0x81000005 -> MEM_ADDR=0, OPCODE=8, MM=1, PC=1, IR_VALID=1, BUSY=0.
REQ-018 IR=0x40000020, BR_SEL=1, PC_SEL pulse -> PC=0x0020; IR=0x5000FFFE at PC=0x0021, brr -> PC=0x001F.
REQ-019 STAT=0100 via FLAGS_WE; bne IR=0x64000100 -> PC unchanged; bne IR=0x63000100 -> PC=0x0100.
REQ-020 PC=0xFFFF, fetch completes -> PC=0x0000; PC_WRITE+PC_SEL same cycle with bra 0x0040 -> MEM_ADDR=0x0040.
REQ-021 MEM_ACK never asserted -> FETCH_ERR=1 after 16 REQ cycles, further PC_WRITE ignored; PC_RST -> IDLE, PC=0, FETCH_ERR=0.
REQ-022 RST_F low mid-REQ -> MEM_REQ=0 immediately, all outputs reset values; MEM_ACK next cycle -> IR stays 0.
